// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-byte SPI peripheral.
//   spi_periph_state_e : peripheral FSM states
//   SPI_BITS_PER_BYTE  : bits per SPI byte
//   count_width()      : width of a counter that must hold 0..max_count
package spi_pkg;

    localparam int SPI_BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_periph_state_e;

    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/spi_peripheral_mb_if.sv
// Host-side byte interface of the SPI peripheral.
//   tx_dv/tx_byte -> peripheral, tx_ready/tx_underrun <- peripheral
//   rx_dv/rx_byte/rx_count <- peripheral
// slave modport is the peripheral's view, master modport the host's view.
interface spi_peripheral_mb_if
    import spi_pkg::*;
#(
    parameter int CW = count_width(4)
);
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_ready;
    logic          tx_underrun;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [CW-1:0] rx_count;

    modport slave (
        input  tx_dv, tx_byte,
        output tx_ready, tx_underrun, rx_dv, rx_byte, rx_count
    );

    modport master (
        output tx_dv, tx_byte,
        input  tx_ready, tx_underrun, rx_dv, rx_byte, rx_count
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with edge pulses.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous pin
//   level    : synchronised level
//   rise     : one-cycle pulse on a synchronised 0->1 transition
//   fall     : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;
endmodule

// File: rtl/spi_peripheral_mb.sv
// Multi-byte SPI mode-0 peripheral. Oversamples the SPI pins on clk,
// deserialises PICO into bytes, serialises queued TX bytes onto POCI and
// counts complete bytes per chip-select window (saturating).
//   clk, rst    : system clock, async active-high reset
//   bus         : host byte interface (slave modport)
//   spi_clk     : SCLK from controller
//   spi_cs_n    : chip select, active low
//   spi_pico    : controller-out data
//   spi_poci    : peripheral-out data
//   spi_poci_oe : POCI output enable
//
// state | meaning
// IDLE  | not selected, POCI released
// LOAD  | CS just fell: load first TX byte, clear counters
// SHIFT | selected: sample on SCLK rise, shift out on SCLK fall
module spi_peripheral_mb
    import spi_pkg::*;
#(
    parameter int         MAX_BYTES_PER_CS = 4,
    parameter logic [7:0] DEFAULT_BYTE     = 8'hFF,
    parameter int         SYNC_STAGES      = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_peripheral_mb_if.slave  bus,
    input  logic                spi_clk,
    input  logic                spi_cs_n,
    input  logic                spi_pico,
    output logic                spi_poci,
    output logic                spi_poci_oe
);
    localparam int CW = count_width(MAX_BYTES_PER_CS);
    localparam int BW = $clog2(SPI_BITS_PER_BYTE);
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_BYTES_PER_CS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(SPI_BITS_PER_BYTE - 1);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_level_unused;
    logic pico_s, pico_rise_unused, pico_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi_clk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // cs_n resets high so an idle bus never looks like a fresh selection.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_pico (
        .clk(clk), .rst(rst), .din(spi_pico),
        .level(pico_s), .rise(pico_rise_unused), .fall(pico_fall_unused)
    );

    spi_periph_state_e state, state_next;

    logic [7:0]    tx_shift, rx_shift, hold_byte, rx_byte_q;
    logic          hold_valid, tx_underrun_q, rx_dv_q;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] rx_count_q;
    logic          reload, shift_tx, rx_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cs_fall) state_next = LOAD;
            LOAD:    state_next = cs_rise ? IDLE : SHIFT;
            SHIFT:   if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        spi_poci_oe  = (state == SHIFT);
        spi_poci     = (state == SHIFT) ? tx_shift[7] : 1'b0;
        bus.tx_ready = ~hold_valid;
    end

    // A CS rise masks any SCLK edge seen in the same cycle.
    assign rx_edge  = (state == SHIFT) && !cs_rise && sclk_rise;
    assign shift_tx = (state == SHIFT) && !cs_rise && sclk_fall && (bit_cnt != '0);
    assign reload   = (state == LOAD) ||
                      ((state == SHIFT) && !cs_rise && sclk_fall && (bit_cnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift      <= '0;
            rx_shift      <= '0;
            hold_byte     <= '0;
            hold_valid    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_dv_q       <= 1'b0;
            rx_byte_q     <= '0;
            rx_count_q    <= '0;
            bit_cnt       <= '0;
        end else begin
            tx_underrun_q <= 1'b0;
            rx_dv_q       <= 1'b0;

            if (reload) begin
                if (hold_valid) begin
                    tx_shift <= hold_byte;
                end else begin
                    tx_shift      <= DEFAULT_BYTE;
                    tx_underrun_q <= 1'b1;
                end
            end else if (shift_tx) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end

            // A reload draining the holding register wins over a write; an
            // empty register still accepts a write in a reload cycle.
            if (reload && hold_valid) begin
                hold_valid <= 1'b0;
            end else if (bus.tx_dv && !hold_valid) begin
                hold_valid <= 1'b1;
                hold_byte  <= bus.tx_byte;
            end

            if (state == LOAD) begin
                rx_count_q <= '0;
                bit_cnt    <= '0;
            end else if (rx_edge) begin
                rx_shift <= {rx_shift[6:0], pico_s};
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    rx_byte_q <= {rx_shift[6:0], pico_s};
                    rx_dv_q   <= 1'b1;
                    if (rx_count_q != MAX_COUNT) rx_count_q <= rx_count_q + 1'b1;
                end
            end
        end
    end

    assign bus.tx_underrun = tx_underrun_q;
    assign bus.rx_dv       = rx_dv_q;
    assign bus.rx_byte     = rx_byte_q;
    assign bus.rx_count    = rx_count_q;
endmodule
